// File: rtl/io_in_pkg.sv
// Shared register map for the memory-mapped input peripheral.
// The same word indices and base address are used by io and the top-level decode.
package io_in_pkg;

  typedef enum logic [1:0] {
    IO_LEVEL  = 2'd0,
    IO_RISE   = 2'd1,
    IO_FALL   = 2'd2,
    IO_IRQ_EN = 2'd3
  } io_reg_e;

  localparam int IO_BASE = 256;

endpackage

// File: rtl/io_in_debounce.sv
// One input bit: optional inversion, 2-flop synchroniser, stability counter and
// accepted level, plus one-cycle rise/fall strobes that coincide with a level update.
module io_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic RST,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          pin_pol;
  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic          accept;

  assign pin_pol = ACTIVE_LOW ? ~pin : pin;

  // The strobes are asserted during the cycle whose edge updates level.
  assign accept = (sync_b != level) && (cnt == CNT_MAX);
  assign rise   = accept && sync_b;
  assign fall   = accept && !sync_b;

  always_ff @(posedge clk) begin
    if (RST) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= pin_pol;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_in.sv
// Memory-mapped input peripheral: debounced pin levels, W1C rise/fall event
// registers, an irq mask and a registered interrupt line.
module io_in
  import io_in_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int IN_WIDTH        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [IN_WIDTH-1:0] pin_in,
  input  logic [1:0]          io_addr,
  input  logic [WIDTH-1:0]    io_data_in,
  input  logic                io_w_en,
  input  logic                io_r_en,
  output logic [WIDTH-1:0]    io_data_out,
  output logic                irq
);

  logic [IN_WIDTH-1:0] level;
  logic [IN_WIDTH-1:0] rise_set;
  logic [IN_WIDTH-1:0] fall_set;
  logic [IN_WIDTH-1:0] rise_q;
  logic [IN_WIDTH-1:0] fall_q;
  logic [IN_WIDTH-1:0] irq_en_q;
  logic [IN_WIDTH-1:0] rise_nxt;
  logic [IN_WIDTH-1:0] fall_nxt;
  logic [IN_WIDTH-1:0] irq_en_nxt;
  logic [IN_WIDTH-1:0] wdata;
  logic                unused_wdata;

  assign wdata        = io_data_in[IN_WIDTH-1:0];
  assign unused_wdata = ^io_data_in;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_bit
    io_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_debounce (
      .clk  (clk),
      .RST  (RST),
      .pin  (pin_in[i]),
      .level(level[i]),
      .rise (rise_set[i]),
      .fall (fall_set[i])
    );
  end

  // Clear is applied before set so a new event in the clearing cycle survives.
  always_comb begin
    rise_nxt   = rise_q;
    fall_nxt   = fall_q;
    irq_en_nxt = irq_en_q;
    if (io_w_en) begin
      case (io_reg_e'(io_addr))
        IO_RISE:   rise_nxt   = rise_q & ~wdata;
        IO_FALL:   fall_nxt   = fall_q & ~wdata;
        IO_IRQ_EN: irq_en_nxt = wdata;
        default:   ;
      endcase
    end
    rise_nxt = rise_nxt | rise_set;
    fall_nxt = fall_nxt | fall_set;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      rise_q   <= rise_nxt;
      fall_q   <= fall_nxt;
      irq_en_q <= irq_en_nxt;
      irq      <= |((rise_nxt | fall_nxt) & irq_en_nxt);
    end
  end

  // Reads come from current register contents, so a same-cycle write is not visible.
  always_comb begin
    io_data_out = '0;
    if (io_r_en) begin
      case (io_reg_e'(io_addr))
        IO_LEVEL:  io_data_out = WIDTH'(level);
        IO_RISE:   io_data_out = WIDTH'(rise_q);
        IO_FALL:   io_data_out = WIDTH'(fall_q);
        IO_IRQ_EN: io_data_out = WIDTH'(irq_en_q);
        default:   io_data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_in.sv
// Self-checking bench for io_in: directed scenarios followed by random pin and bus
// traffic, all compared against a history-window reference model.
module tb_io_in;

  localparam int WIDTH    = 32;
  localparam int IN_WIDTH = 4;
  localparam int DB       = 4;

  logic                clk;
  logic                RST;
  logic [IN_WIDTH-1:0] pin_in;
  logic [1:0]          io_addr;
  logic [WIDTH-1:0]    io_data_in;
  logic                io_w_en;
  logic                io_r_en;
  logic [WIDTH-1:0]    io_data_out;
  logic                irq;

  int vectors;
  int miscompares;

  logic [IN_WIDTH-1:0] pins;

  // Reference model: pin samples taken at each edge, newest at index 0.
  logic [IN_WIDTH-1:0] hist [0:7];
  logic [IN_WIDTH-1:0] m_level;
  logic [IN_WIDTH-1:0] m_rise;
  logic [IN_WIDTH-1:0] m_fall;
  logic [IN_WIDTH-1:0] m_en;
  logic                m_irq;

  io_in #(
    .WIDTH          (WIDTH),
    .IN_WIDTH       (IN_WIDTH),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .pin_in     (pin_in),
    .io_addr    (io_addr),
    .io_data_in (io_data_in),
    .io_w_en    (io_w_en),
    .io_r_en    (io_r_en),
    .io_data_out(io_data_out),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] addr, input logic ren);
    logic [31:0] r;
    r = '0;
    if (ren) begin
      case (addr)
        2'd0: r = 32'(m_level);
        2'd1: r = 32'(m_rise);
        2'd2: r = 32'(m_fall);
        default: r = 32'(m_en);
      endcase
    end
    return r;
  endfunction

  // A synchronised bit is accepted once its last DB synchronised samples all agree
  // and differ from the current level; sync lags the pin sample by two edges.
  task automatic modelEdge(input logic rst, input logic [IN_WIDTH-1:0] p,
                           input logic [1:0] addr, input logic [31:0] wd, input logic wen);
    logic [IN_WIDTH-1:0] setr;
    logic [IN_WIDTH-1:0] setf;
    logic                v;
    logic                stable;
    if (rst) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_en = '0; m_irq = 1'b0;
      return;
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = p;
    setr = '0;
    setf = '0;
    for (int b = 0; b < IN_WIDTH; b++) begin
      v = hist[2][b];
      stable = 1'b1;
      for (int j = 2; j < 2 + DB; j++) if (hist[j][b] != v) stable = 1'b0;
      if (stable && (v != m_level[b])) begin
        m_level[b] = v;
        if (v) setr[b] = 1'b1;
        else   setf[b] = 1'b1;
      end
    end
    if (wen) begin
      case (addr)
        2'd1: m_rise = m_rise & ~wd[IN_WIDTH-1:0];
        2'd2: m_fall = m_fall & ~wd[IN_WIDTH-1:0];
        2'd3: m_en   = wd[IN_WIDTH-1:0];
        default: ;
      endcase
    end
    m_rise = m_rise | setr;
    m_fall = m_fall | setf;
    m_irq  = |((m_rise | m_fall) & m_en);
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] addr, input logic [31:0] wd,
                               input logic wen, input logic ren);
    @(negedge clk);
    RST        = rst;
    pin_in     = pins;
    io_addr    = addr;
    io_data_in = wd;
    io_w_en    = wen;
    io_r_en    = ren;
    #1;
    checkOutput($sformatf("rdata[%0d]", addr), io_data_out, modelRead(addr, ren));
    @(posedge clk);
    modelEdge(rst, pins, addr, wd, wen);
    #1;
    checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n, input logic [1:0] addr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, addr, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] wd);
    applyStimulus(1'b0, addr, wd, 1'b1, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pins        = 4'hF;
    RST         = 1'b1;
    pin_in      = 4'hF;
    io_addr     = 2'd0;
    io_data_in  = '0;
    io_w_en     = 1'b0;
    io_r_en     = 1'b0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    m_level = '0; m_rise = '0; m_fall = '0; m_en = '0; m_irq = 1'b0;

    // Reset held with all pins high, then the 6-clock acceptance latency.
    applyStimulus(1'b1, 2'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd3, 32'h0, 1'b0, 1'b1);
    idle(6, 2'd0);
    @(negedge clk);
    io_addr = 2'd0; io_r_en = 1'b1; io_w_en = 1'b0; RST = 1'b0;
    #1;
    checkOutput("level_after_6", io_data_out, 32'h0000_000F);

    // Drop all pins, clear events, then a held rise on bit0 and a short glitch on bit1.
    pins = 4'h0;
    idle(8, 2'd2);
    busWrite(2'd1, 32'hF);
    busWrite(2'd2, 32'hF);
    pins = 4'h1;
    idle(8, 2'd1);
    pins = 4'h3;
    idle(3, 2'd0);
    pins = 4'h1;
    idle(8, 2'd2);

    // Interrupt masking, partial and full W1C of RISE.
    busWrite(2'd3, 32'h1);
    busWrite(2'd1, 32'hF);
    pins = 4'h0;
    idle(8, 2'd2);
    pins = 4'h1;
    idle(8, 2'd1);
    busWrite(2'd1, 32'h2);
    idle(1, 2'd1);
    busWrite(2'd1, 32'h1);
    idle(2, 2'd1);

    // Continuous W1C on bit0 across a new rise: the set edge must win.
    pins = 4'h0;
    idle(8, 2'd0);
    pins = 4'h1;
    for (int i = 0; i < 10; i++) busWrite(2'd1, 32'h1);
    idle(2, 2'd1);

    // Falling edge on bit2, read-only LEVEL, masked IRQ_EN write.
    pins = 4'h5;
    idle(8, 2'd0);
    pins = 4'h1;
    idle(8, 2'd2);
    busWrite(2'd0, 32'hFFFF_FFFF);
    idle(1, 2'd0);
    busWrite(2'd3, 32'hFFFF_FFF5);
    idle(2, 2'd3);

    // Reset in the middle of a debounce, then a full re-acceptance.
    pins = 4'h0;
    applyStimulus(1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
    pins = 4'h1;
    idle(4, 2'd0);
    applyStimulus(1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
    idle(8, 2'd0);

    // Random pin activity with random bus traffic and rare resets.
    begin
      int hold;
      hold = 0;
      for (int i = 0; i < 600; i++) begin
        if (hold == 0) begin
          pins = IN_WIDTH'($urandom);
          hold = $urandom_range(1, 8);
        end
        hold--;
        applyStimulus(($urandom_range(0, 199) == 0),
                      2'($urandom),
                      $urandom,
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
